// File: rtl/sram22_pkg.sv
// Shared definitions for the sram22 port controller: FSM state type and the
// geometry of the standard 2048x32 macro with a 4-lane write mask.
package sram22_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int SRAM22_2048X32_DATA_WIDTH  = 32;
  localparam int SRAM22_2048X32_ADDR_WIDTH  = 11;
  localparam int SRAM22_2048X32_WMASK_WIDTH = 4;
  localparam int SRAM22_RESP_DEPTH_DEFAULT  = 2;

endpackage

// File: rtl/sram22_resp_fifo.sv
// Small synchronous FIFO that buffers macro read data until the consumer takes it.
// The caller never pushes into a full FIFO without popping in the same cycle.
module sram22_resp_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic          valid,
  output logic [CW-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign valid = (count_q != '0);
  assign count = count_q;

endmodule

// File: rtl/sram22_port_ctrl.sv
// Initiator for the sram22 single-port macro: request channel, credit-limited
// read pipeline into a response FIFO, and an optional post-reset zero-fill sweep.
module sram22_port_ctrl
  import sram22_pkg::*;
#(
  parameter int DATA_WIDTH  = SRAM22_2048X32_DATA_WIDTH,
  parameter int ADDR_WIDTH  = SRAM22_2048X32_ADDR_WIDTH,
  parameter int WMASK_WIDTH = SRAM22_2048X32_WMASK_WIDTH,
  parameter int RESP_DEPTH  = SRAM22_RESP_DEPTH_DEFAULT,
  parameter bit INIT_ZERO   = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [WMASK_WIDTH-1:0] req_wmask,
  input  logic [ADDR_WIDTH-1:0]  req_addr,
  input  logic [DATA_WIDTH-1:0]  req_wdata,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [DATA_WIDTH-1:0]  resp_rdata,
  output logic                   init_done,
  output logic                   sram_we,
  output logic [WMASK_WIDTH-1:0] sram_wmask,
  output logic [ADDR_WIDTH-1:0]  sram_addr,
  output logic [DATA_WIDTH-1:0]  sram_din,
  input  logic [DATA_WIDTH-1:0]  sram_dout,
  output state_e                 dbg_state
);

  localparam int          CW          = $clog2(RESP_DEPTH + 1);
  localparam logic [CW:0] CREDITS     = (CW + 1)'(RESP_DEPTH);
  localparam state_e      RESET_STATE = INIT_ZERO ? ST_INIT : ST_RUN;

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  sweep_q, sweep_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0]  din_q, din_d;
  logic                   rd_inflight_q, rd_inflight_d;
  logic [CW-1:0]          fifo_count;
  logic                   pop;
  logic                   accept;
  logic [CW:0]            occ;

  assign pop = resp_valid & resp_ready;
  // Credits count buffered data plus the read still on the macro pins, minus
  // the entry leaving this cycle; accepting only below RESP_DEPTH means a push never overflows.
  assign occ = {1'b0, fifo_count} + {{CW{1'b0}}, rd_inflight_q} - {{CW{1'b0}}, pop};

  // Request channel: a transfer happens at the posedge where req_valid and req_ready
  // are both high; req_ready never looks at req_valid or req_we.
  always_comb begin
    state_d       = state_q;
    sweep_d       = sweep_q;
    addr_d        = addr_q;
    din_d         = din_q;
    rd_inflight_d = 1'b0;
    req_ready     = 1'b0;
    accept        = 1'b0;
    sram_we       = 1'b0;
    sram_wmask    = '0;
    sram_addr     = addr_q;
    sram_din      = din_q;
    if (rst_n) begin
      if (state_q == ST_INIT) begin
        sram_we    = 1'b1;
        sram_wmask = '1;
        sram_addr  = sweep_q;
        sram_din   = '0;
        addr_d     = sweep_q;
        din_d      = '0;
        sweep_d    = sweep_q + ADDR_WIDTH'(1);
        if (sweep_q == '1) begin
          state_d = ST_RUN;
        end
      end else begin
        req_ready = (occ < CREDITS);
        accept    = req_valid & req_ready;
        if (accept) begin
          sram_we       = req_we;
          sram_wmask    = req_wmask;
          sram_addr     = req_addr;
          sram_din      = req_wdata;
          addr_d        = req_addr;
          din_d         = req_wdata;
          rd_inflight_d = ~req_we;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RESET_STATE;
      sweep_q       <= '0;
      addr_q        <= '0;
      din_q         <= '0;
      rd_inflight_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sweep_q       <= sweep_d;
      addr_q        <= addr_d;
      din_q         <= din_d;
      rd_inflight_q <= rd_inflight_d;
    end
  end

  // Macro dout is only meaningful in the cycle after an accepted read.
  sram22_resp_fifo #(
    .W     (DATA_WIDTH),
    .DEPTH (RESP_DEPTH),
    .CW    (CW)
  ) u_resp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rd_inflight_q),
    .push_data (sram_dout),
    .pop       (pop),
    .rdata     (resp_rdata),
    .valid     (resp_valid),
    .count     (fifo_count)
  );

  assign init_done = !INIT_ZERO || (state_q == ST_RUN);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sram22_port_ctrl.sv
// Bench for sram22_port_ctrl: behavioural sram22 macro, a flat reference memory with an
// expected-response queue, directed scenarios followed by a randomized traffic phase.
module tb_sram22_port_ctrl;
  import sram22_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [3:0]  req_wmask = '0;
  logic [10:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_ready = 1'b0;
  logic        req_ready, resp_valid, init_done, sram_we;
  logic [3:0]  sram_wmask;
  logic [10:0] sram_addr;
  logic [31:0] resp_rdata, sram_din;
  logic [31:0] sram_dout = '0;
  state_e      dbg_state;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] exp_q[$];
  logic [31:0] ref_mem [0:2047];
  int          pop_cyc_q[$];
  int          acc_cyc_q[$];
  logic        last_acc = 1'b0;
  logic        samp_ready = 1'b0;
  logic        hold_prev = 1'b0;
  logic [31:0] hold_data = '0;
  logic [31:0] last_pop_data = '0;

  sram22_port_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_wmask(req_wmask), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .init_done(init_done),
    .sram_we(sram_we), .sram_wmask(sram_wmask), .sram_addr(sram_addr),
    .sram_din(sram_din), .sram_dout(sram_dout),
    .dbg_state(dbg_state)
  );

  // clock / reset-independent clock
  always #5 clk = ~clk;

  // Behavioural sram22 macro: random power-up contents, garbage dout on write cycles.
  logic [31:0] mac_mem [0:2047];
  bit          mac_filled = 1'b0;
  always @(posedge clk) begin
    if (!mac_filled) begin
      for (int i = 0; i < 2048; i++) mac_mem[i] <= $urandom;
      mac_filled <= 1'b1;
    end else if (sram_we) begin
      for (int i = 0; i < 4; i++)
        if (sram_wmask[i]) mac_mem[sram_addr][8*i +: 8] <= sram_din[8*i +: 8];
      sram_dout <= $urandom;
    end else begin
      sram_dout <= mac_mem[sram_addr];
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: inputs already driven after negedge; sample mid-low-phase, update model, advance.
  task automatic cycle();
    logic acc, pop;
    #3;
    acc = (req_valid === 1'b1) && (req_ready === 1'b1);
    pop = (resp_valid === 1'b1) && (resp_ready === 1'b1);
    samp_ready = req_ready;
    if (hold_prev) begin
      check("hold_valid", {31'b0, resp_valid}, 32'd1);
      check("hold_data", resp_rdata, hold_data);
    end
    hold_prev = (resp_valid === 1'b1) && !resp_ready;
    hold_data = resp_rdata;
    if (pop) begin
      pop_cyc_q.push_back(cyc);
      last_pop_data = resp_rdata;
      if (exp_q.size() == 0) check("resp_when_empty", {31'b0, resp_valid}, 32'd0);
      else check("resp_data", resp_rdata, exp_q.pop_front());
    end
    last_acc = acc;
    if (acc) begin
      acc_cyc_q.push_back(cyc);
      if (req_we) begin
        for (int i = 0; i < 4; i++)
          if (req_wmask[i]) ref_mem[req_addr][8*i +: 8] = req_wdata[8*i +: 8];
      end else begin
        exp_q.push_back(ref_mem[req_addr]);
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic send(input logic we, input logic [3:0] m, input logic [10:0] a,
                      input logic [31:0] d);
    int n = 0;
    req_valid = 1'b1; req_we = we; req_wmask = m; req_addr = a; req_wdata = d;
    do begin
      cycle();
      n++;
    end while (!last_acc && n < 100);
    check("send_accept", {31'b0, last_acc}, 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    req_valid = 1'b0;
    resp_ready = 1'b1;
    while (exp_q.size() != 0 && n < 50) begin
      cycle();
      n++;
    end
    repeat (2) cycle();
    check("drain_empty", exp_q.size(), 32'd0);
  endtask

  task automatic wait_init();
    int   n = 0;
    logic bad = 1'b0;
    forever begin
      #3;
      if (init_done === 1'b1 || n >= 3000) break;
      if (req_ready !== 1'b0 || sram_we !== 1'b1 || sram_wmask !== 4'hF ||
          sram_addr !== n[10:0] || sram_din !== 32'h0 || resp_valid !== 1'b0) bad = 1'b1;
      n++;
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check("init_cycles", n, 32'd2048);
    check("init_pins", {31'b0, bad}, 32'd0);
    for (int i = 0; i < 2048; i++) ref_mem[i] = '0;
  endtask

  initial begin
    int          n_acc;
    logic        pending;
    logic [31:0] wd;

    // reset values
    @(negedge clk);
    #3;
    check("rst_req_ready", {31'b0, req_ready}, 32'd0);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_init_done", {31'b0, init_done}, 32'd0);
    check("rst_sram_we", {31'b0, sram_we}, 32'd0);
    check("rst_sram_wmask", {28'b0, sram_wmask}, 32'd0);
    check("rst_sram_addr", {21'b0, sram_addr}, 32'd0);
    check("rst_sram_din", sram_din, 32'd0);
    check("rst_state_init", {31'b0, dbg_state == ST_INIT}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: zero-fill sweep, then top address reads zero
    wait_init();
    send(1'b0, 4'h0, 11'h7FF, 32'h0);
    drain();
    check("t1_top_zero", last_pop_data, 32'h0);

    // 2: byte-lane masked write over a full write
    send(1'b1, 4'hF, 11'h010, 32'h11223344);
    send(1'b1, 4'b0101, 11'h010, 32'hDEADBEEF);
    send(1'b0, 4'h0, 11'h010, 32'h0);
    drain();
    check("t2_masked", last_pop_data, 32'h11AD33EF);

    // 3: back-to-back reads, one response per cycle, 2-cycle first latency
    for (int i = 1; i <= 8; i++) send(1'b1, 4'hF, 11'(i), $urandom);
    req_valid = 1'b0;
    resp_ready = 1'b1;
    cycle();
    pop_cyc_q.delete();
    acc_cyc_q.delete();
    for (int i = 1; i <= 8; i++) send(1'b0, 4'h0, 11'(i), 32'h0);
    drain();
    check("t3_accepts", acc_cyc_q.size(), 32'd8);
    check("t3_accept_span", acc_cyc_q[7] - acc_cyc_q[0], 32'd7);
    check("t3_resp_count", pop_cyc_q.size(), 32'd8);
    check("t3_first_latency", pop_cyc_q[0] - acc_cyc_q[0], 32'd2);
    check("t3_resp_span", pop_cyc_q[7] - pop_cyc_q[0], 32'd7);

    // 4: backpressure: only RESP_DEPTH reads accepted, data held, clean drain
    resp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_wmask = 4'h0; req_addr = 11'h001;
    n_acc = 0;
    pop_cyc_q.delete();
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (last_acc) begin
        n_acc++;
        req_addr = req_addr + 11'd1;
      end
    end
    check("t4_accepts", n_acc, 32'd2);
    check("t4_ready_low", {31'b0, samp_ready}, 32'd0);
    check("t4_no_pop", pop_cyc_q.size(), 32'd0);
    drain();
    check("t4_drained", pop_cyc_q.size(), 32'd2);

    // 5: write then read same address on the next cycle
    send(1'b1, 4'hF, 11'h0F0, 32'hA5A5A5A5);
    send(1'b0, 4'h0, 11'h0F0, 32'h0);
    drain();
    check("t5_wr_then_rd", last_pop_data, 32'hA5A5A5A5);

    // randomized traffic with random gaps and backpressure
    pending = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!pending) begin
        if ($urandom_range(0, 3) != 0) begin
          wd = $urandom;
          req_valid = 1'b1;
          req_we = 1'($urandom_range(0, 1));
          req_wmask = 4'($urandom_range(0, 15));
          req_addr = 11'h100 + 11'($urandom_range(0, 15));
          req_wdata = wd;
        end else begin
          req_valid = 1'b0;
        end
      end
      resp_ready = ($urandom_range(0, 3) != 0);
      cycle();
      pending = req_valid && !last_acc;
    end
    drain();

    // 6: reset with two responses buffered
    resp_ready = 1'b0;
    send(1'b0, 4'h0, 11'h010, 32'h0);
    send(1'b0, 4'h0, 11'h0F0, 32'h0);
    req_valid = 1'b0;
    repeat (3) cycle();
    #3;
    check("t6_full_before", {31'b0, resp_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_valid_drop", {31'b0, resp_valid}, 32'd0);
    check("t6_ready_drop", {31'b0, req_ready}, 32'd0);
    check("t6_init_drop", {31'b0, init_done}, 32'd0);
    exp_q.delete();
    hold_prev = 1'b0;
    repeat (3) @(negedge clk);
    resp_ready = 1'b1;
    rst_n = 1'b1;
    wait_init();
    repeat (3) cycle();
    send(1'b0, 4'h0, 11'h010, 32'h0);
    send(1'b0, 4'h0, 11'h0F0, 32'h0);
    drain();
    check("t6_resweep", last_pop_data, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
